// File: rtl/gn_axis_rr_arb.sv
// Round-robin AXI4-Stream arbiter: P_NUM masters share one registered output stream,
// bursts of up to P_BURST_LEN beats per grant. Optional per-requester counters: GN_AXIS_RR_ARB_STATS_EN.
module gn_axis_rr_arb #(
  parameter int P_NUM       = 2,
  parameter int P_DWIDTH    = 32,
  parameter int P_BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [P_NUM*P_DWIDTH-1:0]   s_axis_tdata,
  input  logic [P_NUM-1:0]            s_axis_tvalid,
  output logic [P_NUM-1:0]            s_axis_tready,
  output logic [P_DWIDTH-1:0]         m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [$clog2(P_NUM)-1:0]    grant_id,
  output logic                        busy
`ifdef GN_AXIS_RR_ARB_STATS_EN
  ,
  output logic [P_NUM*32-1:0]         stat_beat_cnt,
  output logic [P_NUM*16-1:0]         stat_grant_cnt
`endif
);

  localparam int GW = $clog2(P_NUM);
  localparam int CW = $clog2(P_BURST_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                mv_q, mv_d;
  logic [P_DWIDTH-1:0] md_q, md_d;

  logic                out_free, hs, sel_found;
  logic [GW-1:0]       sel_idx, idx;

  // First valid requester after the last grant, wrapping modulo P_NUM.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = grant_q;
    idx       = '0;
    for (int k = 1; k <= P_NUM; k++) begin
      idx = GW'((int'(grant_q) + k) % P_NUM);
      if (!sel_found && s_axis_tvalid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  assign out_free = !mv_q || m_axis_tready;
  assign hs       = (state_q == GRANT) && s_axis_tvalid[grant_q] && out_free;
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    s_axis_tready = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        s_axis_tready[grant_q] = out_free;
        if (hs) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(P_BURST_LEN)) state_d = IDLE;
        end else if (out_free) begin
          // Granted requester went idle with the output free: release early.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mv_d = mv_q;
    md_d = md_q;
    if (hs) begin
      mv_d = 1'b1;
      md_d = s_axis_tdata[grant_q*P_DWIDTH +: P_DWIDTH];
    end else if (m_axis_tready) begin
      mv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= GW'(P_NUM - 1);
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      md_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
    end
  end

  assign m_axis_tdata  = md_q;
  assign m_axis_tvalid = mv_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == GRANT);

`ifdef GN_AXIS_RR_ARB_STATS_EN
  logic [P_NUM-1:0] s_hs;
  assign s_hs = s_axis_tvalid & s_axis_tready;

  for (genvar i = 0; i < P_NUM; i++) begin : g_stat
    logic [31:0] beat_q;
    logic [15:0] gcnt_q;
    logic        gnt_new;
    assign gnt_new = (state_q == IDLE) && sel_found && (sel_idx == GW'(i));
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        beat_q <= '0;
        gcnt_q <= '0;
      end else begin
        if (s_hs[i]) beat_q <= beat_q + 32'd1;
        if (gnt_new) gcnt_q <= gcnt_q + 16'd1;
      end
    end
    assign stat_beat_cnt[i*32 +: 32]  = beat_q;
    assign stat_grant_cnt[i*16 +: 16] = gcnt_q;
  end
`endif

endmodule
